// File: rtl/mc_core.sv
// mc_core: multi-cycle core. Every instruction steps through
// FETCH -> DECODE -> EXEC -> (MEM) -> WB. The instruction ROM is read
// combinationally. Data memory is external and uses a req/ack handshake,
// so RAMs with wait states can be attached.
//
// Ports:
//   clk, reset_n      clock (rising edge) and asynchronous active-low reset
//   start             1-cycle pulse, runs from PC=0 (accepted in IDLE/HALTED only)
//   done              high while in HALTED
//   imem_addr/_data   PC out, 9-bit instruction in (latched at end of FETCH)
//   dmem_req/_we      request (held until ack) / 1 = store
//   dmem_addr/_wdata  r[a]+MEM_OFS / store data r[b]
//   dmem_rdata/_ack   load data (taken on ack) / access complete
//   cyc_cnt           cycle counter over FETCH..WB, saturating
//
// Build option: define MC_CORE_PERF_CNT_EN to implement cyc_cnt; without it
// cyc_cnt is tied to zero and no counter flops exist.
module mc_core #(
  parameter int unsigned W       = 8,
  parameter int unsigned D       = 12,
  parameter int unsigned NREG    = 8,
  parameter int unsigned MEM_OFS = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  output logic         done,
  output logic [D-1:0] imem_addr,
  input  logic [8:0]   imem_data,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [W-1:0] dmem_addr,
  output logic [W-1:0] dmem_wdata,
  input  logic [W-1:0] dmem_rdata,
  input  logic         dmem_ack,
  output logic [31:0]  cyc_cnt
);

  localparam int unsigned RW = $clog2(NREG);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_XOR = 4'h3,
    OP_ADDI = 4'h4, OP_MOV = 4'h5, OP_SHF = 4'h6, OP_CMP = 4'h7,
    OP_BR   = 4'h8, OP_ST  = 4'hC, OP_LD  = 4'hD, OP_HALT = 4'hF
  } op_e;

  state_e         state_q, state_d;
  logic [D-1:0]   pc_q, pcn_q, pcn_d;
  logic [8:0]     ir_q;
  logic [W-1:0]   rf_q [NREG];
  logic           c_q, z_q, lt_q;
  logic           cn_q, zn_q, ltn_q, c_d, z_d, lt_d;
  logic [W-1:0]   opa_q, opb_q, res_q, res_d;
  logic           wen_q, wen_d;
  logic [RW-1:0]  widx_q, widx_d;
  logic [RW-1:0]  a_idx, b_idx;
  logic [3:0]     op;
  logic [W:0]     sum;
  logic           shin, taken, start_ok;

  assign op       = ir_q[8:5];
  assign a_idx    = RW'(ir_q[4:3]);
  assign b_idx    = RW'(ir_q[2:0]);
  assign start_ok = start && (state_q == S_IDLE || state_q == S_HALTED);

  assign done       = (state_q == S_HALTED);
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == S_MEM);
  assign dmem_we    = dmem_req && (op == OP_ST);
  assign dmem_addr  = opa_q + W'(MEM_OFS);
  assign dmem_wdata = opb_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_HALTED: if (start) state_d = S_FETCH;
      S_FETCH:          state_d = S_DECODE;
      S_DECODE:         state_d = (op == OP_HALT) ? S_HALTED : S_EXEC;
      S_EXEC:           state_d = (op == OP_LD || op == OP_ST) ? S_MEM : S_WB;
      S_MEM:            if (dmem_ack) state_d = S_WB;
      S_WB:             state_d = S_FETCH;
      default:          state_d = S_IDLE;
    endcase
  end

  // Execute stage: result, destination and pending flags/PC are computed
  // here and committed together in WB.
  always_comb begin
    res_d  = opb_q;
    c_d    = c_q;
    z_d    = z_q;
    lt_d   = lt_q;
    wen_d  = 1'b0;
    widx_d = b_idx;
    pcn_d  = pc_q + D'(1);
    sum    = '0;
    shin   = ir_q[4] & c_q;
    taken  = 1'b0;
    case (op)
      OP_ADD: begin
        sum   = {1'b0, opb_q} + {1'b0, opa_q};
        res_d = sum[W-1:0];
        c_d   = sum[W];
        wen_d = 1'b1;
      end
      OP_SUB: begin
        // Top bit of the (W+1)-bit difference is the borrow.
        sum   = {1'b0, opb_q} - {1'b0, opa_q};
        res_d = sum[W-1:0];
        c_d   = sum[W];
        wen_d = 1'b1;
      end
      OP_AND: begin res_d = opb_q & opa_q; wen_d = 1'b1; end
      OP_XOR: begin res_d = opb_q ^ opa_q; wen_d = 1'b1; end
      OP_ADDI: begin
        res_d  = opa_q + W'(ir_q[2:0]);
        widx_d = a_idx;
        wen_d  = 1'b1;
      end
      OP_MOV: begin res_d = opb_q; widx_d = a_idx; wen_d = 1'b1; end
      OP_SHF: begin
        if (!ir_q[3]) begin
          res_d = {opb_q[W-2:0], shin};
          c_d   = opb_q[W-1];
        end else begin
          res_d = {shin, opb_q[W-1:1]};
          c_d   = opb_q[0];
        end
        wen_d = 1'b1;
      end
      OP_CMP: begin
        z_d  = (opa_q == opb_q);
        lt_d = (opa_q < opb_q);
      end
      OP_BR: begin
        case (ir_q[4:3])
          2'b00:   taken = 1'b1;
          2'b01:   taken = z_q;
          2'b10:   taken = !z_q;
          default: taken = lt_q;
        endcase
        if (taken) pcn_d = pc_q + D'(signed'(opb_q));
      end
      OP_LD:   wen_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q   <= '0;
      pcn_q  <= '0;
      ir_q   <= '0;
      c_q    <= 1'b0;
      z_q    <= 1'b0;
      lt_q   <= 1'b0;
      cn_q   <= 1'b0;
      zn_q   <= 1'b0;
      ltn_q  <= 1'b0;
      opa_q  <= '0;
      opb_q  <= '0;
      res_q  <= '0;
      wen_q  <= 1'b0;
      widx_q <= '0;
      for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_HALTED: if (start_ok) begin
          pc_q <= '0;
          c_q  <= 1'b0;
        end
        S_FETCH:  ir_q <= imem_data;
        S_DECODE: begin
          opa_q <= rf_q[a_idx];
          opb_q <= rf_q[b_idx];
        end
        S_EXEC: begin
          res_q  <= res_d;
          wen_q  <= wen_d;
          widx_q <= widx_d;
          cn_q   <= c_d;
          zn_q   <= z_d;
          ltn_q  <= lt_d;
          pcn_q  <= pcn_d;
        end
        S_MEM: if (dmem_ack) res_q <= dmem_rdata;
        S_WB: begin
          if (wen_q) rf_q[widx_q] <= res_q;
          c_q  <= cn_q;
          z_q  <= zn_q;
          lt_q <= ltn_q;
          pc_q <= pcn_q;
        end
        default: ;
      endcase
    end
  end

`ifdef MC_CORE_PERF_CNT_EN
  logic [31:0] cnt_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                                    cnt_q <= '0;
    else if (start_ok)                                               cnt_q <= '0;
    else if (state_q != S_IDLE && state_q != S_HALTED && cnt_q != '1) cnt_q <= cnt_q + 32'd1;
  end
  assign cyc_cnt = cnt_q;
`else
  assign cyc_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_core.sv
module tb_mc_core;

  logic        clk = 1'b0;
  logic        reset_n, start, done;
  logic [11:0] imem_addr;
  logic [8:0]  imem_data;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] cyc_cnt;

  always #5 clk = ~clk;

  mc_core #(.W(8), .D(12), .NREG(8), .MEM_OFS(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .done(done),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .cyc_cnt(cyc_cnt)
  );

  logic [8:0]  prog [4096];
  logic [7:0]  dmem [256];
  logic [7:0]  mmem [256];
  int unsigned waits [256];
  int unsigned lens [256];
  assign imem_data = prog[imem_addr];

  // Architectural reference state
  int unsigned mr [8];
  int unsigned mc, mz, mlt;
  typedef struct { bit we; int unsigned addr; int unsigned wdata; } txn_t;
  txn_t expq [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] enc(input int unsigned op, input int unsigned a, input int unsigned b);
    logic [3:0] o = op[3:0];
    logic [1:0] aa = a[1:0];
    logic [2:0] bb = b[2:0];
    return {o, aa, bb};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 4096; i++) prog[i] = enc(15, 0, 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mr[i] = 0;
    mc = 0; mz = 0; mlt = 0;
  endtask

  // Instruction-level interpreter: one loop iteration per instruction,
  // cycle cost taken from the documented latencies.
  task automatic model_run(output int unsigned cycles, output int unsigned halt_pc, output bit ok);
    int unsigned pc, nxt, op, a, b, s, addr, acc, cin, co;
    int off;
    logic [8:0] inst;
    txn_t t;
    bit tk;
    pc = 0; mc = 0; cycles = 0; acc = 0; ok = 0; halt_pc = 0;
    for (int step = 0; step < 4000; step++) begin
      inst = prog[pc];
      op = inst[8:5]; a = inst[4:3]; b = inst[2:0];
      if (op == 15) begin
        cycles += 2; halt_pc = pc; ok = 1;
        return;
      end
      cycles += 4;
      nxt = (pc + 1) % 4096;
      case (op)
        0: begin s = mr[b] + mr[a]; mc = (s > 255); mr[b] = s % 256; end
        1: begin s = (mr[b] + 256 - mr[a]) % 256; mc = (mr[b] < mr[a]); mr[b] = s; end
        2: mr[b] = mr[b] & mr[a];
        3: mr[b] = mr[b] ^ mr[a];
        4: mr[a] = (mr[a] + b) % 256;
        5: mr[a] = mr[b];
        6: begin
          cin = (a >= 2) ? mc : 0;
          if (a % 2 == 0) begin co = mr[b] / 128; mr[b] = (mr[b] * 2 + cin) % 256; end
          else            begin co = mr[b] % 2;   mr[b] = mr[b] / 2 + cin * 128;  end
          mc = co;
        end
        7: begin mz = (mr[a] == mr[b]); mlt = (mr[a] < mr[b]); end
        8: begin
          tk = (a == 0) || (a == 1 && mz != 0) || (a == 2 && mz == 0) || (a == 3 && mlt != 0);
          off = (mr[b] >= 128) ? int'(mr[b]) - 256 : int'(mr[b]);
          if (tk) nxt = int'(pc + 4096) + off;
          nxt = nxt % 4096;
        end
        12, 13: begin
          addr = (mr[a] + 8) % 256;
          t.we = (op == 12); t.addr = addr; t.wdata = mr[b];
          expq.push_back(t);
          if (op == 12) mmem[addr] = mr[b][7:0];
          else          mr[b] = mmem[addr];
          cycles += waits[acc % 256] + 1;
          acc++;
        end
        default: ;
      endcase
      pc = nxt;
    end
  endtask

  // Data RAM: ack is decided on the falling edge for the coming rising edge.
  int unsigned di, wcnt;
  bit          chk_txn;
  logic [7:0]  cap_addr, cap_wdata;
  logic        cap_we;
  always @(negedge clk) begin
    txn_t e;
    if (!reset_n) begin
      dmem_ack = 1'b0;
      wcnt = 0;
    end else if (dmem_req) begin
      if (wcnt == 0) begin
        cap_addr = dmem_addr; cap_we = dmem_we; cap_wdata = dmem_wdata;
      end else begin
        chk("addr_stable", {24'd0, dmem_addr}, {24'd0, cap_addr});
        chk("we_stable", {31'd0, dmem_we}, {31'd0, cap_we});
        chk("wdata_stable", {24'd0, dmem_wdata}, {24'd0, cap_wdata});
      end
      if (wcnt == waits[di % 256]) begin
        dmem_ack   = 1'b1;
        dmem_rdata = dmem[dmem_addr];
        if (dmem_we) dmem[dmem_addr] = dmem_wdata;
        lens[di % 256] = wcnt + 1;
        if (chk_txn) begin
          if (expq.size() == 0) chk("txn_extra", 32'd1, 32'd0);
          else begin
            e = expq.pop_front();
            chk("txn_we", {31'd0, dmem_we}, {31'd0, e.we});
            chk("txn_addr", {24'd0, dmem_addr}, e.addr);
            if (e.we) chk("txn_wdata", {24'd0, dmem_wdata}, e.wdata);
          end
        end
        di++;
        wcnt = 0;
      end else begin
        dmem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      dmem_ack   = 1'($urandom_range(0, 1));
      dmem_rdata = 8'($urandom);
      wcnt = 0;
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    model_reset();
  endtask

  task automatic set_waits(input int unsigned maxw);
    for (int i = 0; i < 256; i++) waits[i] = $urandom_range(0, maxw);
  endtask

  task automatic run_prog(input string tag, input bit mid_start);
    int unsigned exp_cyc, hpc, cnt;
    bit ok;
    expq.delete();
    model_run(exp_cyc, hpc, ok);
    if (!ok) begin
      $display("FAIL %s_model_no_halt", tag);
      $fatal(1);
    end
    di = 0; chk_txn = 1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cnt = 0;
    while (cnt < 5000) begin
      @(posedge clk); cnt++;
      #1;
      if (mid_start && cnt == 2) start = 1'b1;
      if (mid_start && cnt == 3) start = 1'b0;
      if (done) break;
    end
    start = 1'b0;
    chk({tag, "_cycles"}, cnt, exp_cyc);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_halt_pc"}, {20'd0, imem_addr}, hpc);
    chk({tag, "_txn_left"}, expq.size(), 32'd0);
`ifdef MC_CORE_PERF_CNT_EN
    chk({tag, "_cyc_cnt"}, cyc_cnt, exp_cyc);
`else
    chk({tag, "_cyc_cnt"}, cyc_cnt, 32'd0);
`endif
  endtask

  task automatic load_dump(input int unsigned p);
    for (int k = 0; k < 8; k++) prog[p + k] = enc(12, 0, k);
    prog[p + 8] = enc(15, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    int unsigned ops [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 12, 13, 9, 14};
    int unsigned cnt;
    dmem_ack = 1'b0; dmem_rdata = '0; chk_txn = 1; di = 0; wcnt = 0;
    for (int i = 0; i < 256; i++) begin dmem[i] = 8'($urandom); mmem[i] = dmem[i]; end
    clear_prog();
    do_reset();

    // Idle after reset without start
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_done", {31'd0, done}, 32'd0);
      chk("idle_pc", {20'd0, imem_addr}, 32'd0);
      chk("idle_req", {31'd0, dmem_req}, 32'd0);
    end
    chk("idle_cyc_cnt", cyc_cnt, 32'd0);

    // ADDI r1,5; ADDI r1,3; ST [r0],r1; HALT
    clear_prog(); set_waits(0);
    prog[0] = enc(4, 1, 5); prog[1] = enc(4, 1, 3); prog[2] = enc(12, 0, 1);
    run_prog("store", 1'b0);

    // Load with three wait states, then store the loaded value
    clear_prog(); set_waits(0); waits[0] = 3;
    dmem[8] = 8'h5A; mmem[8] = 8'h5A;
    prog[0] = enc(13, 0, 2); prog[1] = enc(12, 0, 2);
    run_prog("load", 1'b0);
    chk("load_req_len", lens[0], 32'd4);

    // Carry from ADD feeding a shift-with-carry
    do_reset(); clear_prog(); set_waits(2);
    prog[0] = enc(4, 2, 1); prog[1] = enc(1, 2, 1); prog[2] = enc(0, 1, 2);
    prog[3] = enc(6, 2, 3); prog[4] = enc(6, 2, 4);
    prog[5] = enc(12, 0, 2); prog[6] = enc(12, 0, 3); prog[7] = enc(12, 0, 4);
    run_prog("carry", 1'b0);

    // Backward conditional branch from PC 10 to 8
    do_reset(); clear_prog(); set_waits(1);
    prog[0] = enc(4, 3, 2); prog[1] = enc(1, 3, 6); prog[2] = enc(4, 2, 1);
    for (int i = 3; i < 8; i++) prog[i] = enc(9, 0, 0);
    prog[8] = enc(4, 1, 1); prog[9] = enc(7, 1, 2); prog[10] = enc(8, 1, 6);
    prog[11] = enc(12, 0, 1);
    run_prog("br_back", 1'b0);

    // Branch at PC 0 by -1 wraps to the top of the program space
    do_reset(); clear_prog(); set_waits(0);
    prog[0] = enc(4, 3, 1); prog[1] = enc(1, 3, 7);
    run_prog("br_prep", 1'b0);
    clear_prog(); prog[0] = enc(8, 0, 7);
    run_prog("br_wrap", 1'b0);

    // Reset asserted while a load is waiting for ack
    clear_prog(); set_waits(0); waits[0] = 50;
    prog[0] = enc(13, 0, 1);
    chk_txn = 0; di = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cnt = 0;
    while (!dmem_req && cnt < 20) begin @(posedge clk); #1; cnt++; end
    chk("rst_req_seen", {31'd0, dmem_req}, 32'd1);
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    chk("rst_req_drop", {31'd0, dmem_req}, 32'd0);
    chk("rst_we_drop", {31'd0, dmem_we}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk); #2 reset_n = 1'b1;
    model_reset();
    #1;
    chk("rst_pc", {20'd0, imem_addr}, 32'd0);
    chk("rst_done_rel", {31'd0, done}, 32'd0);
    chk("rst_cyc_cnt", cyc_cnt, 32'd0);
    clear_prog(); set_waits(1); load_dump(0);
    run_prog("rst_regs", 1'b0);

    // Random programs, register dump at the end; one with a start pulse in EXEC
    for (int r = 0; r < 6; r++) begin
      clear_prog(); set_waits(3);
      for (int i = 0; i < 30; i++)
        prog[i] = enc(ops[$urandom_range(0, 11)], $urandom_range(0, 3), $urandom_range(0, 7));
      if (r == 2) prog[0] = enc(0, $urandom_range(0, 3), $urandom_range(0, 7));
      load_dump(30);
      run_prog($sformatf("rand%0d", r), r == 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
